// File: rtl/regwb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: opcodes, widths, FIFO entry and grant types.
// No logic; types and constants only.
package regwb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] BCC   = 7'b1100011;
    localparam logic [6:0] LCC   = 7'b0000011;
    localparam logic [6:0] SCC   = 7'b0100011;
    localparam logic [6:0] MCC   = 7'b0010011;
    localparam logic [6:0] RCC   = 7'b0110011;
    localparam logic [6:0] SYS   = 7'b1110011;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
        logic                  kill;
        logic [3:0]            age;
    } fifo_ent_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_HEAD,
        GNT_BYP
    } gnt_t;

endpackage

// File: rtl/regwb_fifo2.sv
// Two-entry MDU result queue with per-entry kill-by-rd and head age counter.
// Push/pop take effect at the edge; caller must not push when full.
module regwb_fifo2
    import regwb_arbiter_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RES,
    input  logic                  i_push,
    input  logic [REG_ADDR_W-1:0] i_push_rd,
    input  logic [XLEN-1:0]       i_push_data,
    input  logic                  i_pop,
    input  logic                  i_kill_vld,
    input  logic [REG_ADDR_W-1:0] i_kill_rd,
    output logic                  o_head_vld,
    output logic [REG_ADDR_W-1:0] o_head_rd,
    output logic [XLEN-1:0]       o_head_data,
    output logic                  o_head_kill,
    output logic [3:0]            o_head_age,
    output logic [1:0]            o_count
);

    fifo_ent_t  r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic [1:0] w_valid;

    always_comb begin
        w_valid = '0;
        for (int i = 0; i < 2; i++) begin
            w_valid[i] = (r_count == 2'd2) || ((r_count == 2'd1) && (r_rd_ptr == 1'(i)));
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[1'(i)] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (i_kill_vld && w_valid[i] && (r_mem[1'(i)].rd == i_kill_rd)) begin
                    r_mem[1'(i)].kill <= 1'b1;
                end
            end
            // Only the head ages; the other slot keeps age 0 until it moves up.
            if (r_count != 2'd0) begin
                if (i_pop) begin
                    r_mem[r_rd_ptr].age <= 4'd0;
                end else if (r_mem[r_rd_ptr].age != 4'd15) begin
                    r_mem[r_rd_ptr].age <= r_mem[r_rd_ptr].age + 4'd1;
                end
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // A fresh entry is never killed by a same-cycle PIPE write, so it overrides the kill update.
            if (i_push) begin
                r_mem[r_wr_ptr] <= '{rd: i_push_rd, data: i_push_data, kill: 1'b0, age: 4'd0};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head_vld  = (r_count != 2'd0);
    assign o_head_rd   = r_mem[r_rd_ptr].rd;
    assign o_head_data = r_mem[r_rd_ptr].data;
    assign o_head_kill = r_mem[r_rd_ptr].kill;
    assign o_head_age  = r_mem[r_rd_ptr].age;
    assign o_count     = r_count;

endmodule

// File: rtl/regwb_arbiter.sv
// Register-file write arbiter between the pipeline writeback stage and a multi-cycle unit.
// RF write one cycle after grant; PIPE_stall holds the pipe on starvation, MDU_ready drops when queue full.
module regwb_arbiter
    import regwb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RES,
    input  logic                  PIPE_valid,
    input  logic [REG_ADDR_W-1:0] PIPE_rd,
    input  logic [XLEN-1:0]       PIPE_data,
    output logic                  PIPE_stall,
    input  logic                  MDU_valid,
    input  logic [REG_ADDR_W-1:0] MDU_rd,
    input  logic [XLEN-1:0]       MDU_data,
    output logic                  MDU_ready,
    output logic                  RF_we,
    output logic [REG_ADDR_W-1:0] RF_waddr,
    output logic [XLEN-1:0]       RF_wdata
);

    localparam logic [3:0] LP_STARVE = 4'(STARVE_LIMIT);

    logic                  r_mdu_ready;
    logic                  r_rf_we;
    logic [REG_ADDR_W-1:0] r_rf_waddr;
    logic [XLEN-1:0]       r_rf_wdata;

    logic                  w_head_vld;
    logic [REG_ADDR_W-1:0] w_head_rd;
    logic [XLEN-1:0]       w_head_data;
    logic                  w_head_kill;
    logic [3:0]            w_head_age;
    logic [1:0]            w_count;
    logic [1:0]            w_count_nxt;
    logic                  w_mdu_hs;
    logic                  w_starve;
    gnt_t                  w_gnt;
    logic                  w_stall;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_kill_vld;
    logic                  w_wr_en;
    logic [REG_ADDR_W-1:0] w_wr_rd;
    logic [XLEN-1:0]       w_wr_data;

    assign w_mdu_hs = MDU_valid && r_mdu_ready;
    assign w_starve = w_head_vld && (w_head_age >= LP_STARVE);

    always_comb begin
        w_gnt   = GNT_NONE;
        w_stall = 1'b0;
        if (!RES) begin
            if (w_starve) begin
                w_gnt   = GNT_HEAD;
                w_stall = PIPE_valid;
            end else if (PIPE_valid) begin
                w_gnt = GNT_PIPE;
            end else if (w_head_vld) begin
                w_gnt = GNT_HEAD;
            end else if (w_mdu_hs) begin
                w_gnt = GNT_BYP;
            end
        end
    end

    assign w_push      = !RES && w_mdu_hs && (w_gnt != GNT_BYP);
    assign w_pop       = (w_gnt == GNT_HEAD);
    assign w_kill_vld  = (w_gnt == GNT_PIPE) && (PIPE_rd != '0);
    assign w_count_nxt = w_count + {1'b0, w_push} - {1'b0, w_pop};

    always_comb begin
        w_wr_rd   = '0;
        w_wr_data = '0;
        w_wr_en   = 1'b0;
        case (w_gnt)
            GNT_PIPE: begin
                w_wr_rd   = PIPE_rd;
                w_wr_data = PIPE_data;
                w_wr_en   = (PIPE_rd != '0);
            end
            GNT_HEAD: begin
                w_wr_rd   = w_head_rd;
                w_wr_data = w_head_data;
                w_wr_en   = (w_head_rd != '0) && !w_head_kill;
            end
            GNT_BYP: begin
                w_wr_rd   = MDU_rd;
                w_wr_data = MDU_data;
                w_wr_en   = (MDU_rd != '0);
            end
            default: begin
                w_wr_en = 1'b0;
            end
        endcase
    end

    regwb_fifo2 u_fifo (
        .CLK         (CLK),
        .RES         (RES),
        .i_push      (w_push),
        .i_push_rd   (MDU_rd),
        .i_push_data (MDU_data),
        .i_pop       (w_pop),
        .i_kill_vld  (w_kill_vld),
        .i_kill_rd   (PIPE_rd),
        .o_head_vld  (w_head_vld),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data),
        .o_head_kill (w_head_kill),
        .o_head_age  (w_head_age),
        .o_count     (w_count)
    );

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
            r_mdu_ready <= 1'b1;
        end else begin
            r_rf_we <= w_wr_en;
            if (w_gnt != GNT_NONE) begin
                r_rf_waddr <= w_wr_rd;
                r_rf_wdata <= w_wr_data;
            end
            r_mdu_ready <= (w_count_nxt != 2'd2);
        end
    end

    assign PIPE_stall = w_stall;
    assign MDU_ready  = r_mdu_ready;
    assign RF_we      = r_rf_we;
    assign RF_waddr   = r_rf_waddr;
    assign RF_wdata   = r_rf_wdata;

endmodule

// File: tb/tb_regwb_arbiter.sv
// Scoreboarded bench for regwb_arbiter: expected RF writes are queued as stimulus is driven
// and compared in order whenever RF_we is seen.
module tb_regwb_arbiter;

    logic        CLK = 1'b0;
    logic        RES;
    logic        PIPE_valid;
    logic [4:0]  PIPE_rd;
    logic [31:0] PIPE_data;
    logic        PIPE_stall;
    logic        MDU_valid;
    logic [4:0]  MDU_rd;
    logic [31:0] MDU_data;
    logic        MDU_ready;
    logic        RF_we;
    logic [4:0]  RF_waddr;
    logic [31:0] RF_wdata;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_total = 0;
    int  n_bad   = 0;
    int  acc_cyc;

    regwb_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK        (CLK),
        .RES        (RES),
        .PIPE_valid (PIPE_valid),
        .PIPE_rd    (PIPE_rd),
        .PIPE_data  (PIPE_data),
        .PIPE_stall (PIPE_stall),
        .MDU_valid  (MDU_valid),
        .MDU_rd     (MDU_rd),
        .MDU_data   (MDU_data),
        .MDU_ready  (MDU_ready),
        .RF_we      (RF_we),
        .RF_waddr   (RF_waddr),
        .RF_wdata   (RF_wdata)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic exp_wr(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (RF_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexp_we", {27'd0, RF_waddr}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_rd", {27'd0, RF_waddr}, {27'd0, mon_e.rd});
                check("wr_data", RF_wdata, mon_e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        RES = 1'b1; PIPE_valid = 1'b0; PIPE_rd = '0; PIPE_data = '0;
        MDU_valid = 1'b0; MDU_rd = '0; MDU_data = '0;
        tick(); tick();
        PIPE_valid = 1'b1; PIPE_rd = 5'd2; PIPE_data = 32'hDEAD;
        #1;
        check("rst_stall", PIPE_stall, 0);
        check("rst_we", RF_we, 0);
        check("rst_waddr", RF_waddr, 0);
        check("rst_wdata", RF_wdata, 0);
        check("rst_rdy", MDU_ready, 1);
        check("rst_cnt", dut.w_count, 0);
        tick();
        RES = 1'b0;

        // Plain pipeline write
        PIPE_valid = 1'b1; PIPE_rd = 5'd5; PIPE_data = 32'h11;
        #1;
        check("s1_stall", PIPE_stall, 0);
        exp_wr(5'd5, 32'h11);
        tick();
        PIPE_valid = 1'b0;
        check("s1_we", RF_we, 1);
        check("s1_waddr", RF_waddr, 5);
        tick();
        check("s1_we_low", RF_we, 0);

        // MDU bypass
        MDU_valid = 1'b1; MDU_rd = 5'd7; MDU_data = 32'hAB;
        #1;
        exp_wr(5'd7, 32'hAB);
        tick();
        MDU_valid = 1'b0;
        check("s2_we", RF_we, 1);
        check("s2_cnt", dut.w_count, 0);
        repeat (2) tick();

        // Starvation of a single entry under continuous PIPE_valid
        for (int c = 0; c < 7; c++) begin
            PIPE_valid = 1'b1; PIPE_rd = 5'(10 + c); PIPE_data = 32'h100 + 32'(c);
            MDU_valid = (c == 0); MDU_rd = 5'd9; MDU_data = 32'h99;
            #1;
            check("s3_stall", PIPE_stall, {31'd0, c == 5});
            if (c == 5) exp_wr(5'd9, 32'h99);
            else        exp_wr(PIPE_rd, PIPE_data);
            tick();
        end
        PIPE_valid = 1'b0; MDU_valid = 1'b0;
        check("s3_cnt", dut.w_count, 0);
        repeat (2) tick();

        // Full queue holds off a third MDU result
        acc_cyc = -1;
        for (int c = 0; c < 17; c++) begin
            PIPE_valid = 1'b1; PIPE_rd = 5'(10 + (c % 8)); PIPE_data = 32'h200 + 32'(c);
            if (c == 0) begin
                MDU_valid = 1'b1; MDU_rd = 5'd20; MDU_data = 32'hA0;
            end else if (c == 1) begin
                MDU_valid = 1'b1; MDU_rd = 5'd21; MDU_data = 32'hA1;
            end else if (acc_cyc < 0) begin
                MDU_valid = 1'b1; MDU_rd = 5'd22; MDU_data = 32'hA2;
            end else begin
                MDU_valid = 1'b0;
            end
            #1;
            check("s4_stall", PIPE_stall, {31'd0, (c == 5) || (c == 10) || (c == 15)});
            if (c == 5)       exp_wr(5'd20, 32'hA0);
            else if (c == 10) exp_wr(5'd21, 32'hA1);
            else if (c == 15) exp_wr(5'd22, 32'hA2);
            else              exp_wr(PIPE_rd, PIPE_data);
            if (c == 2 || c == 5) check("s4_rdy_low", MDU_ready, 0);
            if (c == 6)           check("s4_rdy_high", MDU_ready, 1);
            if (c >= 2 && MDU_valid && MDU_ready && acc_cyc < 0) acc_cyc = c;
            tick();
        end
        PIPE_valid = 1'b0; MDU_valid = 1'b0;
        check("s4_acc_cyc", acc_cyc, 6);
        repeat (2) tick();
        check("s4_cnt", dut.w_count, 0);

        // WAW kill, rd 0, and same-cycle enqueue not killed
        PIPE_valid = 1'b1; PIPE_rd = 5'd1; PIPE_data = 32'h31;
        MDU_valid = 1'b1; MDU_rd = 5'd3; MDU_data = 32'h33;
        exp_wr(5'd1, 32'h31);
        tick();
        MDU_valid = 1'b0;
        PIPE_rd = 5'd3; PIPE_data = 32'h55;
        exp_wr(5'd3, 32'h55);
        tick();
        check("s5_waddr", RF_waddr, 3);
        check("s5_wdata", RF_wdata, 32'h55);
        PIPE_rd = 5'd0; PIPE_data = 32'h77;
        tick();
        check("s5_rd0_we", RF_we, 0);
        PIPE_valid = 1'b0;
        tick();
        check("s5_kill_we", RF_we, 0);
        check("s5_cnt", dut.w_count, 0);
        PIPE_valid = 1'b1; PIPE_rd = 5'd4; PIPE_data = 32'h44;
        MDU_valid = 1'b1; MDU_rd = 5'd4; MDU_data = 32'h4B;
        exp_wr(5'd4, 32'h44);
        exp_wr(5'd4, 32'h4B);
        tick();
        PIPE_valid = 1'b0; MDU_valid = 1'b0;
        tick();
        check("s5_same_we", RF_we, 1);
        check("s5_same_data", RF_wdata, 32'h4B);
        repeat (2) tick();

        // Reset with two entries queued
        PIPE_valid = 1'b1; PIPE_rd = 5'd11; PIPE_data = 32'h611;
        MDU_valid = 1'b1; MDU_rd = 5'd25; MDU_data = 32'h625;
        exp_wr(5'd11, 32'h611);
        tick();
        PIPE_rd = 5'd12; PIPE_data = 32'h612;
        MDU_rd = 5'd26; MDU_data = 32'h626;
        exp_wr(5'd12, 32'h612);
        tick();
        MDU_valid = 1'b0;
        check("s6_cnt_full", dut.w_count, 2);
        RES = 1'b1;
        #1;
        check("s6_rst_stall", PIPE_stall, 0);
        tick();
        RES = 1'b0; PIPE_valid = 1'b0;
        check("s6_rdy", MDU_ready, 1);
        check("s6_cnt", dut.w_count, 0);
        for (int c = 0; c < 6; c++) begin
            check("s6_we", RF_we, 0);
            tick();
        end

        check("q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
